// File: rtl/frame_config_sequencer.sv
// rtl/frame_config_sequencer.sv - streams header-addressed frame words into one fabric column
//
// Purpose: accepts a header word (sync 16'hFAB5, column index, frame count N), then N frame
//   words. Each accepted frame word is registered onto FrameData, and a one-cycle one-hot
//   FrameStrobe pulse follows for the selected column. A malformed header sets the sticky
//   cfg_error flag. That header word is dropped and the sequencer stays idle.
// Optional feature: FRAME_SEQ_CHECKSUM_EN adds a trailing checksum word. The checksum is the
//   XOR of all frame words. A mismatch aborts the load without a done pulse.
// Ports:
//   CLK, RESET  - config clock; asynchronous active-high reset
//   in_data     - header / frame / checksum word
//   in_valid    - in_data valid
//   in_ready    - the word is taken when in_valid & in_ready
//   FrameData   - registered frame word; held until the next frame word is accepted
//   FrameStrobe - one-hot, one-cycle write pulse for frame[frame_idx]
//   ColSelect   - one-hot target column; held while the column is loading
//   busy        - high whenever the sequencer is not idle
//   done        - one-cycle pulse after a column loads successfully
//   cfg_error   - sticky error flag; cleared by the next valid header
module frame_config_sequencer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [FrameBitsPerRow-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NumColumns-1:0]      ColSelect,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [7:0]                 NUM_COLS   = 8'(NumColumns);
  localparam logic [7:0]                 MAX_FRAMES = 8'(MaxFramesPerCol);
  localparam logic [MaxFramesPerCol-1:0] STROBE_ONE = MaxFramesPerCol'(1);
  localparam logic [NumColumns-1:0]      COL_ONE    = NumColumns'(1);

  state_t                     state_q, state_d;
  logic [7:0]                 frame_idx_q, frame_idx_d;
  logic [7:0]                 frame_cnt_q, frame_cnt_d;
  logic [NumColumns-1:0]      col_sel_q, col_sel_d;
  logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
  logic                       err_q, err_d;
  logic                       ready_c;
  logic                       accept;
  logic                       hdr_ok;
  logic                       last_frame;
  logic [7:0]                 hdr_col;
  logic [7:0]                 hdr_cnt;

`ifdef FRAME_SEQ_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] csum_q, csum_d;
`endif

  assign hdr_col    = in_data[15:8];
  assign hdr_cnt    = in_data[7:0];
  assign hdr_ok     = (in_data[31:16] == 16'hFAB5) && (hdr_cnt != 8'd0) &&
                      (hdr_cnt <= MAX_FRAMES) && (hdr_col < NUM_COLS);
  assign last_frame = (frame_idx_q == frame_cnt_q - 8'd1);
  assign accept     = in_valid && ready_c;

  always_comb begin
    state_d      = state_q;
    frame_idx_d  = frame_idx_q;
    frame_cnt_d  = frame_cnt_q;
    col_sel_d    = col_sel_q;
    frame_data_d = frame_data_q;
    err_d        = err_q;
    ready_c      = 1'b0;
`ifdef FRAME_SEQ_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (in_valid) begin
          if (hdr_ok) begin
            state_d     = S_LOAD;
            col_sel_d   = COL_ONE << hdr_col;
            frame_cnt_d = hdr_cnt;
            frame_idx_d = 8'd0;
            err_d       = 1'b0;
`ifdef FRAME_SEQ_CHECKSUM_EN
            csum_d      = '0;
`endif
          end else begin
            // A bad header is consumed and dropped. Only the sticky flag records it.
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        ready_c = 1'b1;
        if (in_valid) begin
          frame_data_d = in_data;
          state_d      = S_STROBE;
`ifdef FRAME_SEQ_CHECKSUM_EN
          csum_d       = csum_q ^ in_data;
`endif
        end
      end
      S_STROBE: begin
        if (last_frame) begin
`ifdef FRAME_SEQ_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          frame_idx_d = frame_idx_q + 8'd1;
          state_d     = S_LOAD;
        end
      end
      S_CHECK: begin
`ifdef FRAME_SEQ_CHECKSUM_EN
        ready_c = 1'b1;
        if (in_valid) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            err_d     = 1'b1;
            col_sel_d = '0;
            state_d   = S_IDLE;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        col_sel_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      frame_idx_q  <= 8'd0;
      frame_cnt_q  <= 8'd0;
      col_sel_q    <= '0;
      frame_data_q <= '0;
      err_q        <= 1'b0;
`ifdef FRAME_SEQ_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      frame_idx_q  <= frame_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      col_sel_q    <= col_sel_d;
      frame_data_q <= frame_data_d;
      err_q        <= err_d;
`ifdef FRAME_SEQ_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // While RESET is asserted, the ready output is gated low. This keeps every output at
  // zero during reset.
  assign in_ready    = ready_c && !RESET;
  assign FrameData   = frame_data_q;
  assign FrameStrobe = (state_q == S_STROBE) ? (STROBE_ONE << frame_idx_q) : '0;
  assign ColSelect   = col_sel_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign cfg_error   = err_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// tb/tb_frame_config_sequencer.sv - table-driven scoreboard bench for frame_config_sequencer
module tb_frame_config_sequencer;

  logic        CLK;
  logic        RESET;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic [3:0]  ColSelect;
  logic        busy;
  logic        done;
  logic        cfg_error;

  frame_config_sequencer #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(20),
    .NumColumns(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .ColSelect(ColSelect),
    .busy(busy),
    .done(done),
    .cfg_error(cfg_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] seed;
    int          gap;
    bit          exp_ok;
    logic [3:0]  exp_col;
    int          exp_n;
  } vec_t;

  typedef struct {
    logic [19:0] strobe;
    logic [31:0] data;
  } sb_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          strobe_cnt = 0;
  bit          prev_strobe = 0;
  logic [3:0]  exp_col = '0;
  sb_t         sb[$];
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      if (FrameStrobe != '0) begin
        sb_t e;
        strobe_cnt++;
        chk("strobe_onehot", 64'($onehot(FrameStrobe)), 64'd1);
        chk("ready_low_in_strobe", 64'(in_ready), 64'd0);
        chk("colselect_held", 64'(ColSelect), 64'(exp_col));
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 64'(FrameStrobe), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("strobe_value", 64'(FrameStrobe), 64'(e.strobe));
          chk("frame_data", 64'(FrameData), 64'(e.data));
        end
      end
      if (done) begin
        done_cnt++;
`ifndef FRAME_SEQ_CHECKSUM_EN
        chk("done_after_last_strobe", 64'(prev_strobe), 64'd1);
`endif
      end
      prev_strobe = (FrameStrobe != '0);
    end else begin
      prev_strobe = 0;
    end
  end

  task automatic send(input logic [31:0] w, output bit ok);
    int t;
    t  = 0;
    ok = 0;
    @(negedge CLK);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (in_ready) begin
      @(posedge CLK);
      ok = 1;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 40) begin
      @(negedge CLK);
      #1;
      if (!busy) break;
      t++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic apply(input vec_t v);
    bit          ok;
    int          d0;
    int          s0;
    int          g;
    logic [31:0] x;
    logic [31:0] w;
    sb_t         e;
    d0 = done_cnt;
    s0 = strobe_cnt;
    x  = '0;
    exp_col = v.exp_col;
    send(v.hdr, ok);
    chk("hdr_accept", 64'(ok), 64'd1);
    @(negedge CLK);
    chk("cfg_error_after_hdr", 64'(cfg_error), 64'(!v.exp_ok));
    chk("busy_after_hdr", 64'(busy), 64'(v.exp_ok));
    chk("colselect_after_hdr", 64'(ColSelect), 64'(v.exp_col));
    if (v.exp_ok) begin
      for (int i = 0; i < v.exp_n; i++) begin
        w = v.seed + 32'(i);
        x = x ^ w;
        e.strobe = 20'd1 << i;
        e.data   = w;
        sb.push_back(e);
        send(w, ok);
        chk("frame_accept", 64'(ok), 64'd1);
        g = (v.gap < 0) ? int'($urandom_range(0, 5)) : v.gap;
        repeat (g) @(negedge CLK);
      end
`ifdef FRAME_SEQ_CHECKSUM_EN
      send(x, ok);
      chk("checksum_accept", 64'(ok), 64'd1);
`endif
    end
    wait_idle();
    chk("done_count", 64'(done_cnt - d0), 64'(v.exp_ok));
    chk("strobe_count", 64'(strobe_cnt - s0), 64'(v.exp_ok ? v.exp_n : 0));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("colselect_cleared", 64'(ColSelect), 64'd0);
  endtask

  initial begin
    bit ok;
    sb_t e;
    vecs[0] = '{32'hFAB5_0203, 32'h0000_000A, 0,  1'b1, 4'b0100, 3};
    vecs[1] = '{32'h1234_0001, 32'h0,         0,  1'b0, 4'b0000, 0};
    vecs[2] = '{32'hFAB5_0001, 32'h5555_0000, 2,  1'b1, 4'b0001, 1};
    vecs[3] = '{32'hFAB5_0403, 32'h0,         0,  1'b0, 4'b0000, 0};
    vecs[4] = '{32'hFAB5_0300, 32'h0,         0,  1'b0, 4'b0000, 0};
    vecs[5] = '{32'hFAB5_0315, 32'h0,         0,  1'b0, 4'b0000, 0};
    vecs[6] = '{32'hFAB5_0314, 32'hC0DE_0100, -1, 1'b1, 4'b1000, 20};
    vecs[7] = '{32'hFAB5_0105, 32'h1234_5670, 5,  1'b1, 4'b0010, 5};

    RESET    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2 RESET = 1'b1;
    #1;
    chk("rst_strobe", 64'(FrameStrobe), 64'd0);
    chk("rst_colsel", 64'(ColSelect), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(cfg_error), 64'd0);
    chk("rst_data", 64'(FrameData), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1 chk("idle_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) apply(vecs[i]);

    // Assert reset in the strobe cycle of the second frame of an N=5 load.
    exp_col = 4'b0010;
    send(32'hFAB5_0105, ok);
    for (int i = 0; i < 2; i++) begin
      e.strobe = 20'd1 << i;
      e.data   = 32'hBEEF_0000 + 32'(i);
      sb.push_back(e);
      send(e.data, ok);
    end
    #1;
    chk("pre_reset_strobe", 64'(FrameStrobe), 64'h2);
    RESET = 1'b1;
    #1;
    chk("async_rst_strobe", 64'(FrameStrobe), 64'd0);
    chk("async_rst_colsel", 64'(ColSelect), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    sb.delete();
    @(negedge CLK);
    RESET = 1'b0;
    apply(vecs[0]);

`ifdef FRAME_SEQ_CHECKSUM_EN
    begin
      int d0;
      d0 = done_cnt;
      exp_col = 4'b0001;
      send(32'hFAB5_0002, ok);
      for (int i = 0; i < 2; i++) begin
        e.strobe = 20'd1 << i;
        e.data   = 32'(i + 1);
        sb.push_back(e);
        send(e.data, ok);
      end
      send(32'h4, ok);
      wait_idle();
      chk("csum_bad_error", 64'(cfg_error), 64'd1);
      chk("csum_bad_no_done", 64'(done_cnt - d0), 64'd0);
      chk("csum_bad_colsel", 64'(ColSelect), 64'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
